// File: rtl/reg_status_file_pkg.sv
// Shared configuration for the architectural register file and its rename status.
// Sizes the ROB tag, the register array and the zero register.
package reg_status_file_pkg;

    localparam int ROB_SIZE_LOG = 4;
    localparam int ROB_SIZE     = 1 << ROB_SIZE_LOG;
    localparam int REG_COUNT    = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int XLEN         = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       word_t;

    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational operand read port: returns value or pending ROB tag,
// with x0 forced to zero and a same-cycle bypass of a matching commit.
module reg_read_port
    import reg_status_file_pkg::*;
#(
    parameter int TAG_W = ROB_SIZE_LOG
) (
    input  logic [REG_ADDR_W-1:0]             addr,
    input  logic [REG_COUNT-1:0][XLEN-1:0]    val_q,
    input  logic [REG_COUNT-1:0]              busy_q,
    input  logic [REG_COUNT-1:0][TAG_W-1:0]   tag_q,
    input  logic                              commit_send,
    input  logic [REG_ADDR_W-1:0]             commit_reg,
    input  logic [XLEN-1:0]                   commit_value,
    input  logic [TAG_W-1:0]                  commit_reorder,
    output logic                              busy,
    output logic [XLEN-1:0]                   val,
    output logic [TAG_W-1:0]                  reorder
);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        busy    = 1'b0;
        val     = '0;
        reorder = '0;
        if (!is_zero_reg(addr)) begin
            busy    = busy_q[addr];
            val     = val_q[addr];
            reorder = tag_q[addr];
            // The producer is committing right now: hand its value straight through.
            if (busy_q[addr] && commit_send && commit_reg == addr
                && commit_reorder == tag_q[addr]) begin
                busy = 1'b0;
                val  = commit_value;
            end
        end
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Consumes the ROB commit stream and flush; serves two operand read ports.
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int ROB_SIZE_LOG = reg_status_file_pkg::ROB_SIZE_LOG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    clear,
    input  logic                    issue_valid,
    input  logic [REG_ADDR_W-1:0]   issue_rd,
    input  logic [ROB_SIZE_LOG-1:0] issue_reorder,
    input  logic                    commit_send,
    input  logic [REG_ADDR_W-1:0]   commit_reg,
    input  logic [XLEN-1:0]         commit_value,
    input  logic [ROB_SIZE_LOG-1:0] commit_reorder,
    input  logic [REG_ADDR_W-1:0]   rs1_addr,
    output logic                    rs1_busy,
    output logic [XLEN-1:0]         rs1_val,
    output logic [ROB_SIZE_LOG-1:0] rs1_reorder,
    input  logic [REG_ADDR_W-1:0]   rs2_addr,
    output logic                    rs2_busy,
    output logic [XLEN-1:0]         rs2_val,
    output logic [ROB_SIZE_LOG-1:0] rs2_reorder
);

    logic [REG_COUNT-1:0][XLEN-1:0]         val_q;
    logic [REG_COUNT-1:0]                   busy_q;
    logic [REG_COUNT-1:0][ROB_SIZE_LOG-1:0] tag_q;

    logic do_commit;
    logic do_issue;
    logic commit_retires;

    assign do_commit = commit_send && !is_zero_reg(commit_reg);
    assign do_issue  = issue_valid && !is_zero_reg(issue_rd) && !clear;

    // A younger issue to the same register keeps ownership even if the tag matches.
    assign commit_retires = busy_q[commit_reg] && tag_q[commit_reg] == commit_reorder
                            && !(do_issue && issue_rd == commit_reg);

    // NOTE: the whole array is reset asynchronously because consumers must read
    // a defined zero value and idle status straight out of reset; this forces
    // flops rather than a RAM macro, which the register count allows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else if (rdy) begin
            // NOTE: non-blocking updates let later statements override earlier
            // ones for the same register while all conditions see pre-edge state.
            if (clear) begin
                busy_q <= '0;
            end
            if (do_commit) begin
                val_q[commit_reg] <= commit_value;
                if (commit_retires) begin
                    busy_q[commit_reg] <= 1'b0;
                end
            end
            if (do_issue) begin
                busy_q[issue_rd] <= 1'b1;
                tag_q[issue_rd]  <= issue_reorder;
            end
        end
    end

    reg_read_port #(.TAG_W(ROB_SIZE_LOG)) u_rs1 (
        .addr           (rs1_addr),
        .val_q          (val_q),
        .busy_q         (busy_q),
        .tag_q          (tag_q),
        .commit_send    (commit_send),
        .commit_reg     (commit_reg),
        .commit_value   (commit_value),
        .commit_reorder (commit_reorder),
        .busy           (rs1_busy),
        .val            (rs1_val),
        .reorder        (rs1_reorder)
    );

    reg_read_port #(.TAG_W(ROB_SIZE_LOG)) u_rs2 (
        .addr           (rs2_addr),
        .val_q          (val_q),
        .busy_q         (busy_q),
        .tag_q          (tag_q),
        .commit_send    (commit_send),
        .commit_reg     (commit_reg),
        .commit_value   (commit_value),
        .commit_reorder (commit_reorder),
        .busy           (rs2_busy),
        .val            (rs2_val),
        .reorder        (rs2_reorder)
    );

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_reg_status_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_reorder;
    logic        commit_send;
    logic [4:0]  commit_reg;
    logic [31:0] commit_value;
    logic [3:0]  commit_reorder;
    logic [4:0]  rs1_addr;
    logic        rs1_busy;
    logic [31:0] rs1_val;
    logic [3:0]  rs1_reorder;
    logic [4:0]  rs2_addr;
    logic        rs2_busy;
    logic [31:0] rs2_val;
    logic [3:0]  rs2_reorder;

    int n_checks = 0;
    int n_passed = 0;
    bit started  = 1'b0;

    reg_status_file dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clear          (clear),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_reorder  (issue_reorder),
        .commit_send    (commit_send),
        .commit_reg     (commit_reg),
        .commit_value   (commit_value),
        .commit_reorder (commit_reorder),
        .rs1_addr       (rs1_addr),
        .rs1_busy       (rs1_busy),
        .rs1_val        (rs1_val),
        .rs1_reorder    (rs1_reorder),
        .rs2_addr       (rs2_addr),
        .rs2_busy       (rs2_busy),
        .rs2_val        (rs2_val),
        .rs2_reorder    (rs2_reorder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural value, pending flag and owning tag per register.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i]  <= '0;
                m_busy[i] <= 1'b0;
                m_tag[i]  <= '0;
            end
        end else if (rdy) begin
            if (clear) begin
                for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
            end
            if (commit_send && commit_reg != 5'd0) begin
                m_val[commit_reg] <= commit_value;
                if (m_busy[commit_reg] && m_tag[commit_reg] == commit_reorder)
                    m_busy[commit_reg] <= 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0 && !clear) begin
                m_busy[issue_rd] <= 1'b1;
                m_tag[issue_rd]  <= issue_reorder;
            end
        end
    end

    task automatic exp_read(input logic [4:0] a, output logic b, output logic [31:0] v,
                            output logic [3:0] t);
        b = 1'b0;
        v = '0;
        t = '0;
        if (a != 5'd0) begin
            b = m_busy[a];
            v = m_val[a];
            t = m_tag[a];
            if (b && commit_send && commit_reg == a && commit_reorder == t) begin
                b = 1'b0;
                v = commit_value;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Every cycle: both read ports against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            logic        eb;
            logic [31:0] ev;
            logic [3:0]  et;
            exp_read(rs1_addr, eb, ev, et);
            check("rs1_busy", {31'd0, rs1_busy}, {31'd0, eb});
            if (!eb) check("rs1_val", rs1_val, ev);
            else     check("rs1_reorder", {28'd0, rs1_reorder}, {28'd0, et});
            exp_read(rs2_addr, eb, ev, et);
            check("rs2_busy", {31'd0, rs2_busy}, {31'd0, eb});
            if (!eb) check("rs2_val", rs2_val, ev);
            else     check("rs2_reorder", {28'd0, rs2_reorder}, {28'd0, et});
        end
    end

    task automatic idle();
        rdy            = 1'b1;
        clear          = 1'b0;
        issue_valid    = 1'b0;
        issue_rd       = '0;
        issue_reorder  = '0;
        commit_send    = 1'b0;
        commit_reg     = '0;
        commit_value   = '0;
        commit_reorder = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
        issue_valid   = 1'b1;
        issue_rd      = rd;
        issue_reorder = tag;
    endtask

    task automatic commit(input logic [4:0] r, input logic [3:0] tag, input logic [31:0] v);
        commit_send    = 1'b1;
        commit_reg     = r;
        commit_reorder = tag;
        commit_value   = v;
    endtask

    task automatic lit1(input string nm, input logic b, input logic [31:0] v, input logic [3:0] t);
        #1;
        check({nm, "_busy"}, {31'd0, rs1_busy}, {31'd0, b});
        if (b) check({nm, "_reorder"}, {28'd0, rs1_reorder}, {28'd0, t});
        else   check({nm, "_val"}, rs1_val, v);
    endtask

    initial begin
        rst      = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        started = 1'b1;

        rs1_addr = 5'd5;
        lit1("reset_x5", 1'b0, 32'h0, 4'h0);

        // Rename then commit with same-cycle bypass.
        issue(5'd3, 4'd2);
        tick();
        rs1_addr = 5'd3;
        lit1("x3_pending", 1'b1, 32'h0, 4'd2);
        check("model_x3_tag", {28'd0, m_tag[3]}, 32'd2);
        commit(5'd3, 4'd2, 32'hDEADBEEF);
        lit1("x3_bypass", 1'b0, 32'hDEADBEEF, 4'd0);
        tick();
        lit1("x3_stored", 1'b0, 32'hDEADBEEF, 4'd0);

        // Older writer commits while a younger one owns x7.
        issue(5'd7, 4'd1);
        tick();
        issue(5'd7, 4'd4);
        tick();
        commit(5'd7, 4'd1, 32'd11);
        tick();
        rs1_addr = 5'd7;
        lit1("x7_younger_owns", 1'b1, 32'd0, 4'd4);
        check("x7_val_under_rename", dut.val_q[7], 32'd11);
        check("model_x7_val", m_val[7], 32'd11);
        commit(5'd7, 4'd4, 32'd22);
        tick();
        lit1("x7_retired", 1'b0, 32'd22, 4'd0);

        // Same-cycle commit and issue to x9.
        commit(5'd9, 4'd5, 32'h10);
        issue(5'd9, 4'd6);
        tick();
        rs1_addr = 5'd9;
        lit1("x9_reissued", 1'b1, 32'd0, 4'd6);
        check("x9_val_kept", dut.val_q[9], 32'h10);

        // Flush with a simultaneous commit and a discarded issue.
        issue(5'd4, 4'd3);
        tick();
        clear = 1'b1;
        commit(5'd1, 4'd0, 32'h80);
        issue(5'd2, 4'd7);
        tick();
        rs1_addr = 5'd1;
        lit1("x1_after_clear", 1'b0, 32'h80, 4'd0);
        rs1_addr = 5'd4;
        lit1("x4_cleared", 1'b0, 32'd0, 4'd0);
        rs1_addr = 5'd2;
        lit1("x2_issue_dropped", 1'b0, 32'd0, 4'd0);
        check("model_x2_busy", {31'd0, m_busy[2]}, 32'd0);

        // x0 is immutable; rdy=0 freezes everything.
        issue(5'd0, 4'd1);
        commit(5'd0, 4'd1, 32'd5);
        tick();
        rs1_addr = 5'd0;
        lit1("x0_zero", 1'b0, 32'd0, 4'd0);
        rdy = 1'b0;
        issue(5'd6, 4'd3);
        commit(5'd6, 4'd0, 32'h66);
        tick();
        rs1_addr = 5'd6;
        lit1("x6_frozen", 1'b0, 32'd0, 4'd0);

        // Randomized traffic, biased toward register collisions.
        for (int i = 0; i < 2000; i++) begin
            rdy            = ($urandom_range(7) != 0);
            clear          = ($urandom_range(15) == 0);
            issue_valid    = $urandom_range(1);
            issue_rd       = 5'($urandom_range(31));
            issue_reorder  = 4'($urandom_range(15));
            commit_send    = $urandom_range(1);
            commit_reg     = ($urandom_range(3) == 0) ? issue_rd : 5'($urandom_range(31));
            commit_reorder = $urandom_range(1) ? m_tag[commit_reg] : 4'($urandom_range(15));
            commit_value   = $urandom;
            rs1_addr       = ($urandom_range(2) == 0) ? commit_reg : 5'($urandom_range(31));
            rs2_addr       = ($urandom_range(2) == 0) ? issue_rd : 5'($urandom_range(31));
            @(posedge clk);
            #1;
        end
        idle();

        // Asynchronous reset in the middle of a cycle.
        commit(5'd5, 4'd0, 32'h55);
        issue(5'd5, 4'd9);
        tick();
        rs1_addr = 5'd5;
        lit1("x5_before_reset", 1'b1, 32'd0, 4'd9);
        check("x5_val_before_reset", dut.val_q[5], 32'h55);
        #1;
        rst = 1'b0;
        lit1("x5_async_reset", 1'b0, 32'd0, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        lit1("x5_after_reset", 1'b0, 32'd0, 4'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
